vector_checker: RTL and testbench

Synthesizable stimulus/response engine for the processor datapath blocks. It holds a small table of `{d, q_expected}` vector pairs and drives `d` into a device under test (DUT) one vector per clock. It samples the DUT's `q` a fixed number of cycles later and counts mismatches. It sits beside a DUT such as a resettable register or a pipeline stage, on the opposite side of the DUT's data interface, so that on-board self-test does not need a simulator.

---
 rtl/vector_checker_pkg.sv | 18 +
 rtl/vchk_delay_line.sv | 42 ++++
 rtl/vector_checker.sv | 181 ++++++++++++++++++
 tb/tb_vector_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: shared types and constants for the vector_checker
// stimulus/response engine and its delay line.
package vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vchk_state_t;

  // Deepest DUT pipeline the checker can track.
  localparam int VCHK_MAX_LATENCY = 8;

  // The error counter sticks here instead of wrapping back to zero.
  localparam logic [31:0] VCHK_ERR_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/vchk_delay_line.sv
// vchk_delay_line: LATENCY-deep shift line carrying {valid, expected}
// alongside the DUT pipeline. Only the valid bits are reset; the payload
// is don't-care whenever its valid bit is low.
module vchk_delay_line #(
  parameter int W       = 64,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid_i,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  output logic [W-1:0] pop_data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [W-1:0]       data_q [LATENCY];

  // Shift the valid bits one stage per clock, flushing them on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= push_valid_i;
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Shift the expected values in lockstep with their valid bits.
  always_ff @(posedge clk) begin
    data_q[0] <= push_data_i;
    for (int s = 1; s < LATENCY; s++) begin
      data_q[s] <= data_q[s-1];
    end
  end

  assign pop_valid_o = valid_q[LATENCY-1];
  assign pop_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/vector_checker.sv
// vector_checker: drives stored d vectors into a DUT one per clock and
// compares the DUT's q against the stored expected value LATENCY cycles
// later. Optional first-mismatch capture is built when the macro
// VECTOR_CHECKER_FIRST_ERR_EN is defined.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int N       = 64,
  parameter int DEPTH   = 10,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tv_we,
  input  logic [$clog2(DEPTH)-1:0]   tv_addr,
  input  logic [2*N-1:0]             tv_wdata,
  input  logic [$clog2(DEPTH):0]     num_vectors,
  input  logic                       start,
  input  logic [N-1:0]               q_in,
  output logic [N-1:0]               d_out,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                vectornum,
  output logic [31:0]                errors
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  ,
  output logic                       first_err_valid,
  output logic [31:0]                first_err_index,
  output logic [N-1:0]               first_err_q
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(VCHK_MAX_LATENCY);

  vchk_state_t    state_q;
  logic [CW-1:0]  ptr_q;
  logic [CW-1:0]  n_q;
  logic [CW-1:0]  n_start;
  logic [DW-1:0]  drain_q;
  logic [N-1:0]   d_out_q;
  logic           busy_q;
  logic           done_q;

  logic [2*N-1:0] vec_table_q [DEPTH];
  logic [2*N-1:0] rd_entry;
  logic           table_open;
  logic           run_start;

  logic           line_valid;
  logic [N-1:0]   line_exp;
  logic           cmp_valid_q;
  logic [N-1:0]   cmp_exp_q;
  logic           mismatch;
  logic [31:0]    vectornum_q;
  logic [31:0]    errors_q;

  // A run is clamped to the table size. A start in DONE is honoured only once
  // done is visible, so the final compare of the previous run is never lost
  // to the counter clear.
  assign n_start    = (num_vectors > CW'(DEPTH)) ? CW'(DEPTH) : num_vectors;
  assign table_open = (state_q == IDLE) || (state_q == DONE);
  assign run_start  = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));
  assign rd_entry   = vec_table_q[ptr_q[AW-1:0]];

  // Table writes are accepted only while no run is reading the table.
  always_ff @(posedge clk) begin
    if (tv_we && table_open && (int'(tv_addr) < DEPTH)) begin
      vec_table_q[tv_addr] <= tv_wdata;
    end
  end

  // Main sequencer: issue n vectors, drain the DUT pipeline, then park in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      n_q     <= '0;
      drain_q <= '0;
      d_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_q == RUN) || (state_q == DRAIN);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE, DONE: begin
          if (run_start) begin
            n_q     <= n_start;
            ptr_q   <= '0;
            state_q <= (n_start == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          d_out_q <= rd_entry[2*N-1:N];
          ptr_q   <= ptr_q + CW'(1);
          if (ptr_q == (n_q - CW'(1))) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == DW'(LATENCY - 1)) begin
            state_q <= DONE;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vchk_delay_line #(
    .W       (N),
    .LATENCY (LATENCY)
  ) u_line (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (state_q == RUN),
    .push_data_i  (rd_entry[N-1:0]),
    .pop_valid_o  (line_valid),
    .pop_data_o   (line_exp)
  );

  // One alignment stage after the line: the DUT's q is valid for the whole
  // cycle after its LATENCY-th edge, and is compared on the edge that ends it.
  always_ff @(posedge clk) begin
    cmp_exp_q <= line_exp;
  end

  assign mismatch = (q_in != cmp_exp_q);

  // Count compares and mismatches; the error count saturates, the vector count wraps.
  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      cmp_valid_q <= 1'b0;
      vectornum_q <= '0;
      errors_q    <= '0;
    end else begin
      cmp_valid_q <= line_valid;
      if (cmp_valid_q) begin
        vectornum_q <= vectornum_q + 32'd1;
        if (mismatch && (errors_q != VCHK_ERR_SAT)) begin
          errors_q <= errors_q + 32'd1;
        end
      end
    end
  end

`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  logic          fe_valid_q;
  logic [31:0]   fe_index_q;
  logic [N-1:0]  fe_q_q;

  // Latch the index and observed q of the first mismatch in a run.
  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      fe_valid_q <= 1'b0;
      fe_index_q <= '0;
      fe_q_q     <= '0;
    end else if (cmp_valid_q && mismatch && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_index_q <= vectornum_q;
      fe_q_q     <= q_in;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_index = fe_index_q;
  assign first_err_q     = fe_q_q;
`endif

  assign d_out     = d_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vectornum = vectornum_q;
  assign errors    = errors_q;

endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: two checkers looped back through resettable register
// chains, one with LATENCY=1 and one with LATENCY=3, sharing the table-write bus.
module tb_vector_checker;

   localparam int N     = 64;
   localparam int DEPTH = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          tvWe;
   logic [3:0]    tvAddr;
   logic [127:0]  tvWdata;
   logic [4:0]    numVectors;
   logic          start1;
   logic          start3;

   logic [63:0]   dOut1, qIn1;
   logic [63:0]   dOut3, qIn3, stageA, stageB;
   logic          busy1, done1, busy3, done3;
   logic [31:0]   vectornum1, errors1, vectornum3, errors3;
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
   logic          feValid1, feValid3;
   logic [31:0]   feIndex1, feIndex3;
   logic [63:0]   feQ1, feQ3;
`endif

   int vectorsApplied = 0;
   int miscompares    = 0;
   int cyc;
   int busyCyc;

   always #5 clk = ~clk;

   vector_checker #(.N(N), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .tv_we(tvWe), .tv_addr(tvAddr), .tv_wdata(tvWdata),
      .num_vectors(numVectors), .start(start1), .q_in(qIn1), .d_out(dOut1),
      .busy(busy1), .done(done1), .vectornum(vectornum1), .errors(errors1)
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
      , .first_err_valid(feValid1), .first_err_index(feIndex1), .first_err_q(feQ1)
`endif
   );

   vector_checker #(.N(N), .DEPTH(DEPTH), .LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .tv_we(tvWe), .tv_addr(tvAddr), .tv_wdata(tvWdata),
      .num_vectors(numVectors), .start(start3), .q_in(qIn3), .d_out(dOut3),
      .busy(busy3), .done(done3), .vectornum(vectornum3), .errors(errors3)
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
      , .first_err_valid(feValid3), .first_err_index(feIndex3), .first_err_q(feQ3)
`endif
   );

   // Single 64-bit resettable register standing in for the LATENCY=1 DUT.
   always_ff @(posedge clk) begin
      if (reset) qIn1 <= '0;
      else       qIn1 <= dOut1;
   end

   // Three-stage register chain standing in for the LATENCY=3 DUT.
   always_ff @(posedge clk) begin
      if (reset) begin
         stageA <= '0;
         stageB <= '0;
         qIn3   <= '0;
      end else begin
         stageA <= dOut3;
         stageB <= stageA;
         qIn3   <= stageB;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Writes one table entry; called just after a rising edge.
   task automatic applyStimulus(input logic [3:0] addr, input logic [63:0] d, input logic [63:0] q);
      tvWe    = 1'b1;
      tvAddr  = addr;
      tvWdata = {d, q};
      @(posedge clk); #1;
      tvWe    = 1'b0;
   endtask

   // Pulses start on one checker and counts cycles until done; with disturb set,
   // extra start pulses and a table write are thrown in while the run is active.
   task automatic runChecker(input bit useL3, input logic [4:0] nv, input bit disturb,
                             output int cycles, output int busyCycles);
      numVectors = nv;
      if (useL3) start3 = 1'b1;
      else       start1 = 1'b1;
      @(posedge clk); #1;
      start1     = 1'b0;
      start3     = 1'b0;
      cycles     = 0;
      busyCycles = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         cycles++;
         if (useL3 ? busy3 : busy1) busyCycles++;
         if (useL3 ? done3 : done1) break;
         start1  = disturb && (cycles == 2 || cycles == 5);
         tvWe    = disturb && (cycles == 3);
         tvAddr  = 4'd5;
         tvWdata = {64'h55, 64'h99};
      end
      start1 = 1'b0;
      tvWe   = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      tvWe       = 1'b0;
      tvAddr     = '0;
      tvWdata    = '0;
      numVectors = '0;
      start1     = 1'b0;
      start3     = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      checkOutput("resetDOut",      dOut1,            64'd0);
      checkOutput("resetBusy",      64'(busy1),       64'd0);
      checkOutput("resetDone",      64'(done1),       64'd0);
      checkOutput("resetVectornum", 64'(vectornum1),  64'd0);
      checkOutput("resetErrors",    64'(errors1),     64'd0);

      for (int i = 0; i < DEPTH; i++) applyStimulus(4'(i), 64'(i), 64'(i));

      $display("[TB] zero-length run");
      runChecker(1'b0, 5'd0, 1'b0, cyc, busyCyc);
      checkOutput("zeroCycles",    64'(cyc),        64'd1);
      checkOutput("zeroBusy",      64'(busyCyc),    64'd0);
      checkOutput("zeroVectornum", 64'(vectornum1), 64'd0);
      checkOutput("zeroErrors",    64'(errors1),    64'd0);

      $display("[TB] loopback run, LATENCY=1");
      runChecker(1'b0, 5'd10, 1'b0, cyc, busyCyc);
      checkOutput("l1Cycles",    64'(cyc),        64'd12);
      checkOutput("l1Busy",      64'(busyCyc),    64'd11);
      checkOutput("l1Vectornum", 64'(vectornum1), 64'd10);
      checkOutput("l1Errors",    64'(errors1),    64'd0);
      checkOutput("l1LastD",     dOut1,           64'd9);

      $display("[TB] injected mismatches");
      applyStimulus(4'd3, 64'h3, 64'h0);
      applyStimulus(4'd7, 64'h7, 64'hFF);
      runChecker(1'b0, 5'd10, 1'b0, cyc, busyCyc);
      checkOutput("injVectornum", 64'(vectornum1), 64'd10);
      checkOutput("injErrors",    64'(errors1),    64'd2);
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
      checkOutput("injFirstValid", 64'(feValid1), 64'd1);
      checkOutput("injFirstIndex", 64'(feIndex1), 64'd3);
      checkOutput("injFirstQ",     feQ1,          64'h3);
`endif
      applyStimulus(4'd3, 64'h3, 64'h3);
      applyStimulus(4'd7, 64'h7, 64'h7);

      $display("[TB] register chain run, LATENCY=3");
      runChecker(1'b1, 5'd5, 1'b0, cyc, busyCyc);
      checkOutput("l3Cycles",    64'(cyc),        64'd9);
      checkOutput("l3Busy",      64'(busyCyc),    64'd8);
      checkOutput("l3Vectornum", 64'(vectornum3), 64'd5);
      checkOutput("l3Errors",    64'(errors3),    64'd0);
      checkOutput("l3LastD",     dOut3,           64'd4);
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
      checkOutput("l3FirstValid", 64'(feValid3), 64'd0);
`endif

      $display("[TB] oversize run length");
      runChecker(1'b0, 5'd15, 1'b0, cyc, busyCyc);
      checkOutput("clampCycles",    64'(cyc),        64'd12);
      checkOutput("clampVectornum", 64'(vectornum1), 64'd10);
      checkOutput("clampErrors",    64'(errors1),    64'd0);
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
      checkOutput("clampFirstValid", 64'(feValid1), 64'd0);
`endif

      $display("[TB] reset during run, then restart");
      numVectors = 5'd10;
      start1     = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midRunBusy", 64'(busy1), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midResetDOut",      dOut1,           64'd0);
      checkOutput("midResetBusy",      64'(busy1),      64'd0);
      checkOutput("midResetDone",      64'(done1),      64'd0);
      checkOutput("midResetVectornum", 64'(vectornum1), 64'd0);
      checkOutput("midResetErrors",    64'(errors1),    64'd0);
      runChecker(1'b0, 5'd10, 1'b0, cyc, busyCyc);
      checkOutput("restartCycles",    64'(cyc),        64'd12);
      checkOutput("restartVectornum", 64'(vectornum1), 64'd10);
      checkOutput("restartErrors",    64'(errors1),    64'd0);

      $display("[TB] start and table writes during a run");
      runChecker(1'b0, 5'd10, 1'b1, cyc, busyCyc);
      checkOutput("ignoreCycles",    64'(cyc),        64'd12);
      checkOutput("ignoreVectornum", 64'(vectornum1), 64'd10);
      checkOutput("ignoreErrors",    64'(errors1),    64'd0);
      checkOutput("ignoreLastD",     dOut1,           64'd9);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
